// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, exception-redirect kill and stall bubble.
// Latency 1 cycle in->out. Without PIPE_STAGE_SKID_EN, in_ready = out_ready || !out_valid; with it, a registered skid entry decouples in_ready.
module pipe_stage_reg #(
    parameter int PC_W = 32,
    parameter int PAYLOAD_W = 160,
    parameter int EXC_W = 5,
    parameter logic [PC_W-1:0] EXC_PC = PC_W'(32'h0000_4180)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PC_W-1:0]      in_pc,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic [EXC_W-1:0]     in_exc_code,
    input  logic                 in_delay_slot,
    input  logic                 bubble,
    input  logic                 req,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PC_W-1:0]      out_pc,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [EXC_W-1:0]     out_exc_code,
    output logic                 out_delay_slot,
    output logic [1:0]           occupancy
);

    logic                 main_vld_q, main_vld_d;
    logic [PC_W-1:0]      main_pc_q, main_pc_d;
    logic [PAYLOAD_W-1:0] main_pay_q, main_pay_d;
    logic [EXC_W-1:0]     main_exc_q, main_exc_d;
    logic                 main_ds_q, main_ds_d;
    logic                 in_xfer, out_xfer;

`ifdef PIPE_STAGE_SKID_EN
    logic                 skid_vld_q, skid_vld_d;
    logic [PC_W-1:0]      skid_pc_q, skid_pc_d;
    logic [PAYLOAD_W-1:0] skid_pay_q, skid_pay_d;
    logic [EXC_W-1:0]     skid_exc_q, skid_exc_d;
    logic                 skid_ds_q, skid_ds_d;

    // in_ready comes straight from a flop, so it never depends on out_ready this cycle
    assign in_ready  = !skid_vld_q;
    assign occupancy = {1'b0, main_vld_q} + {1'b0, skid_vld_q};
`else
    assign in_ready  = out_ready || !main_vld_q;
    assign occupancy = {1'b0, main_vld_q};
`endif

    assign out_xfer = main_vld_q && out_ready;
    assign in_xfer  = in_valid && in_ready && !req && !bubble;

    always_comb begin
        main_vld_d = main_vld_q;
        main_pc_d  = main_pc_q;
        main_pay_d = main_pay_q;
        main_exc_d = main_exc_q;
        main_ds_d  = main_ds_q;
`ifdef PIPE_STAGE_SKID_EN
        skid_vld_d = skid_vld_q;
        skid_pc_d  = skid_pc_q;
        skid_pay_d = skid_pay_q;
        skid_exc_d = skid_exc_q;
        skid_ds_d  = skid_ds_q;
`endif
        if (req) begin
            main_vld_d = 1'b0;
            main_pc_d  = EXC_PC;
            main_pay_d = '0;
            main_exc_d = '0;
            main_ds_d  = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
            skid_vld_d = 1'b0;
`endif
        end else if (bubble) begin
            main_vld_d = 1'b0;
            main_pc_d  = in_pc;
            main_pay_d = '0;
            main_exc_d = '0;
            main_ds_d  = in_delay_slot;
`ifdef PIPE_STAGE_SKID_EN
            skid_vld_d = 1'b0;
`endif
        end else begin
`ifdef PIPE_STAGE_SKID_EN
            if (skid_vld_q) begin
                // skid full means in_ready is low, so only the drain path can fire
                if (out_xfer) begin
                    main_vld_d = 1'b1;
                    main_pc_d  = skid_pc_q;
                    main_pay_d = skid_pay_q;
                    main_exc_d = skid_exc_q;
                    main_ds_d  = skid_ds_q;
                    skid_vld_d = 1'b0;
                end
            end else if (!main_vld_q || out_xfer) begin
                main_vld_d = in_xfer;
                if (in_xfer) begin
                    main_pc_d  = in_pc;
                    main_pay_d = in_payload;
                    main_exc_d = in_exc_code;
                    main_ds_d  = in_delay_slot;
                end
            end else if (in_xfer) begin
                skid_vld_d = 1'b1;
                skid_pc_d  = in_pc;
                skid_pay_d = in_payload;
                skid_exc_d = in_exc_code;
                skid_ds_d  = in_delay_slot;
            end
`else
            if (in_xfer) begin
                main_vld_d = 1'b1;
                main_pc_d  = in_pc;
                main_pay_d = in_payload;
                main_exc_d = in_exc_code;
                main_ds_d  = in_delay_slot;
            end else if (out_xfer) begin
                main_vld_d = 1'b0;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            main_vld_q <= 1'b0;
            main_pc_q  <= '0;
            main_pay_q <= '0;
            main_exc_q <= '0;
            main_ds_q  <= 1'b0;
`ifdef PIPE_STAGE_SKID_EN
            skid_vld_q <= 1'b0;
            skid_pc_q  <= '0;
            skid_pay_q <= '0;
            skid_exc_q <= '0;
            skid_ds_q  <= 1'b0;
`endif
        end else begin
            main_vld_q <= main_vld_d;
            main_pc_q  <= main_pc_d;
            main_pay_q <= main_pay_d;
            main_exc_q <= main_exc_d;
            main_ds_q  <= main_ds_d;
`ifdef PIPE_STAGE_SKID_EN
            skid_vld_q <= skid_vld_d;
            skid_pc_q  <= skid_pc_d;
            skid_pay_q <= skid_pay_d;
            skid_exc_q <= skid_exc_d;
            skid_ds_q  <= skid_ds_d;
`endif
        end
    end

    assign out_valid      = main_vld_q;
    assign out_pc         = main_pc_q;
    assign out_payload    = main_pay_q;
    assign out_exc_code   = main_exc_q;
    assign out_delay_slot = main_ds_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: the expected stage contents are a FIFO queue whose capacity
// is 1 (default) or 2 (PIPE_STAGE_SKID_EN); kills (reset/req/bubble) empty it and fix the visible fields.
module tb_pipe_stage_reg;

`ifdef PIPE_STAGE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    typedef struct packed {
        logic [31:0]  pc;
        logic [159:0] pay;
        logic [4:0]   exc;
        logic         ds;
    } item_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [31:0]  in_pc = '0;
    logic [159:0] in_payload = '0;
    logic [4:0]   in_exc_code = '0;
    logic         in_delay_slot = 1'b0;
    logic         bubble = 1'b0;
    logic         req = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [31:0]  out_pc;
    logic [159:0] out_payload;
    logic [4:0]   out_exc_code;
    logic         out_delay_slot;
    logic [1:0]   occupancy;

    item_t        exp_q[$];
    int           n_vec = 0;
    int           n_err = 0;
    bit           mon_en = 1'b0;
    bit           kill_vld = 1'b0;
    logic [31:0]  kill_pc;
    logic         kill_ds;

    pipe_stage_reg dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_payload(in_payload), .in_exc_code(in_exc_code), .in_delay_slot(in_delay_slot),
        .bubble(bubble), .req(req),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_payload(out_payload), .out_exc_code(out_exc_code), .out_delay_slot(out_delay_slot),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit model_in_ready(input int cnt, input logic ordy);
        if (CAP == 2) return cnt < 2;
        return ordy || (cnt == 0);
    endfunction

    // Drive one cycle of inputs, then account for what the following edge did to the stage.
    task automatic step(input logic iv, input logic [31:0] pc, input logic ds, input logic ordy,
                        input logic rq, input logic bb, input logic rst);
        item_t it;
        bit    acc;
        it.pc  = pc;
        it.ds  = ds;
        it.exc = 5'($urandom());
        for (int i = 0; i < 5; i++) it.pay[i*32 +: 32] = $urandom();
        in_valid      = iv;
        in_pc         = it.pc;
        in_payload    = it.pay;
        in_exc_code   = it.exc;
        in_delay_slot = it.ds;
        out_ready     = ordy;
        req           = rq;
        bubble        = bb;
        reset         = rst;
        acc = !rst && !rq && !bb && iv && model_in_ready(exp_q.size(), ordy);
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        if (rst) begin
            exp_q.delete();
            kill_vld = 1'b1; kill_pc = 32'h0; kill_ds = 1'b0;
        end else if (rq) begin
            exp_q.delete();
            kill_vld = 1'b1; kill_pc = 32'h0000_4180; kill_ds = 1'b0;
        end else if (bb) begin
            exp_q.delete();
            kill_vld = 1'b1; kill_pc = pc; kill_ds = ds;
        end else if (acc) begin
            exp_q.push_back(it);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("out_valid", {159'd0, out_valid}, {159'd0, exp_q.size() != 0});
            chk("occupancy", {158'd0, occupancy}, 160'(exp_q.size()));
            if (!reset)
                chk("in_ready", {159'd0, in_ready}, {159'd0, model_in_ready(exp_q.size(), out_ready)});
            if (kill_vld) begin
                chk("kill_pc", {128'd0, out_pc}, {128'd0, kill_pc});
                chk("kill_payload", out_payload, 160'd0);
                chk("kill_exc", {155'd0, out_exc_code}, 160'd0);
                chk("kill_ds", {159'd0, out_delay_slot}, {159'd0, kill_ds});
                kill_vld = 1'b0;
            end
            if (out_valid && exp_q.size() != 0) begin
                chk("out_pc", {128'd0, out_pc}, {128'd0, exp_q[0].pc});
                chk("out_payload", out_payload, exp_q[0].pay);
                chk("out_exc", {155'd0, out_exc_code}, {155'd0, exp_q[0].exc});
                chk("out_ds", {159'd0, out_delay_slot}, {159'd0, exp_q[0].ds});
                if (out_ready && !req && !bubble && !reset)
                    void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        step(0, 32'h0, 0, 1, 0, 0, 1);
        step(0, 32'h0, 0, 1, 0, 0, 1);
        // first transfer after reset appears one cycle later
        step(1, 32'h3000, 0, 1, 0, 0, 0);
        step(1, 32'h3004, 0, 1, 0, 0, 0);
        step(0, 32'h0, 0, 0, 0, 0, 0);
        step(0, 32'h0, 0, 0, 1, 0, 0);
        step(0, 32'h3008, 1, 0, 0, 1, 0);
        step(0, 32'h0, 0, 1, 0, 0, 0);
        // fill under backpressure, hold, then drain in order
        step(1, 32'h3000, 0, 0, 0, 0, 0);
        step(1, 32'h3004, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 32'h0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 32'h0, 0, 1, 0, 0, 0);
        step(1, 32'h300c, 0, 0, 0, 0, 0);
        step(1, 32'h3010, 1, 1, 1, 1, 1);
        step(0, 32'h0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) != 0,
                 32'h3000 + 32'($urandom_range(0, 4095)) * 4,
                 1'($urandom()),
                 $urandom_range(0, 2) != 0,
                 $urandom_range(0, 29) == 0,
                 $urandom_range(0, 29) == 0,
                 $urandom_range(0, 199) == 0);
        end
        step(0, 32'h0, 0, 1, 0, 0, 0);
        step(0, 32'h0, 0, 1, 0, 0, 0);
        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
